// File: rtl/fruta_gen_pkg.sv
// Shared snake-game definitions: map cell encodings, fruit generator states
// and the initial fruit position used by both the generator and the update stage.
package fruta_gen_pkg;

  typedef enum logic [1:0] {
    CELL_VAZIA = 2'b00,
    CELL_COBRA = 2'b01,
    CELL_FRUTA = 2'b10,
    CELL_OBST  = 2'b11
  } cell_t;

  typedef enum logic [2:0] {
    IDLE,
    SORTEIA,
    LE,
    CHECA,
    VARRE_LE,
    VARRE_CHECA,
    ENTREGA
  } fruta_state_t;

  localparam logic [9:0]  FRUTA_X0  = 10'd13;
  localparam logic [9:0]  FRUTA_Y0  = 10'd13;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/fruta_gen_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), restarted from the
// shared seed on reset and advanced on every clock otherwise.
module lfsr16
  import fruta_gen_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] lfsr_out
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  always_comb begin
    fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d = {fb, lfsr_q[15:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr_out = lfsr_q;

endmodule

// File: rtl/fruta_gen.sv
// Fruit position generator: draws random candidate cells from the map, and
// after MAX_TENT occupied draws falls back to a row-major scan for an empty cell.
module fruta_gen
  import fruta_gen_pkg::*;
#(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30,
  parameter int MAX_TENT    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fruta_enable,
  output logic       fruta_wenable,
  output logic [9:0] fruta_wx,
  output logic [9:0] fruta_wy,
  output logic       busy,
  output logic       map_renable,
  output logic [9:0] map_rx,
  output logic [9:0] map_ry,
  input  logic [1:0] map_rdata,
  output logic       mapa_cheio
);

  localparam int         CW     = $clog2(MAX_TENT + 1);
  localparam logic [9:0] W_LIM  = 10'(MAPA_WIDTH);
  localparam logic [9:0] H_LIM  = 10'(MAPA_HEIGHT);
  localparam logic [9:0] X_LAST = 10'(MAPA_WIDTH - 1);
  localparam logic [9:0] Y_LAST = 10'(MAPA_HEIGHT - 1);
  localparam logic [CW-1:0] TENT_LIM = CW'(MAX_TENT);

  fruta_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [9:0]    cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [9:0]    map_rx_q, map_rx_d, map_ry_q, map_ry_d;
  logic [9:0]    wx_q, wx_d, wy_q, wy_d;
  logic          map_ren_q, map_ren_d;
  logic          wen_q, wen_d;
  logic          busy_q, busy_d;
  logic          cheio_q, cheio_d;

  logic [15:0]   lfsr;
  logic [9:0]    rnd_x, rnd_y, scan_nx, scan_ny;
  logic          cell_vazia;
  logic          lfsr_unused;

  lfsr16 u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .lfsr_out (lfsr)
  );

  assign rnd_x       = {4'b0, lfsr[5:0]};
  assign rnd_y       = {5'b0, lfsr[12:8]};
  assign lfsr_unused = ^{lfsr[15:13], lfsr[7:6]};
  assign cell_vazia  = (map_rdata == CELL_VAZIA);
  assign cnt_inc     = cnt_q + CW'(1);

  // The candidate register doubles as the scan pointer during the fallback scan.
  assign scan_nx = (cand_x_q == X_LAST) ? 10'd0 : cand_x_q + 10'd1;
  assign scan_ny = (cand_x_q == X_LAST) ? cand_y_q + 10'd1 : cand_y_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_x_d  = cand_x_q;
    cand_y_d  = cand_y_q;
    map_ren_d = 1'b0;
    map_rx_d  = map_rx_q;
    map_ry_d  = map_ry_q;
    wx_d      = wx_q;
    wy_d      = wy_q;
    wen_d     = 1'b0;
    busy_d    = busy_q;
    cheio_d   = cheio_q;
    case (state_q)
      IDLE: begin
        if (fruta_enable) begin
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SORTEIA;
        end
      end
      SORTEIA: begin
        if (rnd_x < W_LIM && rnd_y < H_LIM) begin
          cand_x_d  = rnd_x;
          cand_y_d  = rnd_y;
          map_rx_d  = rnd_x;
          map_ry_d  = rnd_y;
          map_ren_d = 1'b1;
          state_d   = LE;
        end
      end
      LE: state_d = CHECA;
      CHECA: begin
        if (cell_vazia) begin
          wx_d    = cand_x_q;
          wy_d    = cand_y_q;
          wen_d   = 1'b1;
          cheio_d = 1'b0;
          state_d = ENTREGA;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TENT_LIM) begin
            cand_x_d  = '0;
            cand_y_d  = '0;
            map_rx_d  = '0;
            map_ry_d  = '0;
            map_ren_d = 1'b1;
            state_d   = VARRE_LE;
          end else begin
            state_d = SORTEIA;
          end
        end
      end
      VARRE_LE: state_d = VARRE_CHECA;
      VARRE_CHECA: begin
        if (cell_vazia) begin
          wx_d    = cand_x_q;
          wy_d    = cand_y_q;
          wen_d   = 1'b1;
          cheio_d = 1'b0;
          state_d = ENTREGA;
        end else if (cand_x_q == X_LAST && cand_y_q == Y_LAST) begin
          // No free cell anywhere: report it but keep the old fruit position.
          wen_d   = 1'b1;
          cheio_d = 1'b1;
          state_d = ENTREGA;
        end else begin
          cand_x_d  = scan_nx;
          cand_y_d  = scan_ny;
          map_rx_d  = scan_nx;
          map_ry_d  = scan_ny;
          map_ren_d = 1'b1;
          state_d   = VARRE_LE;
        end
      end
      ENTREGA: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cand_x_q  <= '0;
      cand_y_q  <= '0;
      map_ren_q <= 1'b0;
      map_rx_q  <= '0;
      map_ry_q  <= '0;
      wx_q      <= FRUTA_X0;
      wy_q      <= FRUTA_Y0;
      wen_q     <= 1'b0;
      busy_q    <= 1'b0;
      cheio_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_x_q  <= cand_x_d;
      cand_y_q  <= cand_y_d;
      map_ren_q <= map_ren_d;
      map_rx_q  <= map_rx_d;
      map_ry_q  <= map_ry_d;
      wx_q      <= wx_d;
      wy_q      <= wy_d;
      wen_q     <= wen_d;
      busy_q    <= busy_d;
      cheio_q   <= cheio_d;
    end
  end

  assign fruta_wenable = wen_q;
  assign fruta_wx      = wx_q;
  assign fruta_wy      = wy_q;
  assign busy          = busy_q;
  assign map_renable   = map_ren_q;
  assign map_rx        = map_rx_q;
  assign map_ry        = map_ry_q;
  assign mapa_cheio    = cheio_q;

endmodule

// File: doc/fruta_gen.md
FRUTA_GEN -- requirements
Module: fruta_gen

Interface
REQ-001 Parameter MAPA_WIDTH, default 40: map columns, cell x range 0..MAPA_WIDTH-1.
REQ-002 Parameter MAPA_HEIGHT, default 30: map rows, cell y range 0..MAPA_HEIGHT-1.
REQ-003 Parameter MAX_TENT, default 16: random candidates tried before falling back to a linear scan.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 fruta_enable  in  1  request for a new fruit position; one-cycle pulse from the update stage.
REQ-007 fruta_wenable  out  1  one-cycle pulse: new position valid on fruta_wx/fruta_wy.
REQ-008 fruta_wx / fruta_wy  out  10 each  fruit cell; held stable between deliveries.
REQ-009 busy  out  1  high from request acceptance until the cycle after delivery.
REQ-010 map_renable  out  1  map read strobe.
REQ-011 map_rx / map_ry  out  10 each  map read address.
REQ-012 map_rdata  in  2  cell contents, valid the cycle after map_renable; 00 empty, 01 snake, 10 fruit, 11 obstacle.
REQ-013 mapa_cheio  out  1  sticky flag: last request found no empty cell.

Function
REQ-014 A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) SHALL advance every cycle outside reset, independent of state.
REQ-015 States SHALL be IDLE, SORTEIA, LE, CHECA, VARRE_LE, VARRE_CHECA, ENTREGA.
REQ-016 IDLE: fruta_enable=1 -> clear attempt counter, busy=1, go SORTEIA; fruta_enable while busy SHALL be ignored (no queuing).
REQ-017 SORTEIA: candidate x = lfsr[5:0], y = lfsr[12:8]; if x>=MAPA_WIDTH or y>=MAPA_HEIGHT, reject and stay in SORTEIA without counting an attempt; else latch candidate, go LE.
REQ-018 LE: map_renable=1 for exactly one cycle with map_rx/map_ry = candidate; go CHECA.
REQ-019 CHECA: map_rdata==00 -> go ENTREGA; else attempt counter +1; counter==MAX_TENT -> reset scan pointer to (0,0), go VARRE_LE; else go SORTEIA.
REQ-020 VARRE_LE/VARRE_CHECA: row-major scan (x increments first; x wraps MAPA_WIDTH-1 -> 0 with y+1), one read then one check per cell; first cell with 00 becomes candidate, go ENTREGA.
REQ-021 Scan reaching (MAPA_WIDTH-1, MAPA_HEIGHT-1) without an empty cell SHALL set mapa_cheio=1, leave fruta_wx/fruta_wy unchanged, pulse fruta_wenable, return IDLE.
REQ-022 ENTREGA: load candidate into fruta_wx/fruta_wy, fruta_wenable=1 for one cycle, clear mapa_cheio, go IDLE; busy SHALL fall on the following cycle.
REQ-023 Minimum request-to-delivery latency SHALL be 4 cycles (SORTEIA, LE, CHECA, ENTREGA) with an accepted first draw.
REQ-024 map_renable SHALL be 0 in IDLE, SORTEIA, CHECA, VARRE_CHECA, ENTREGA.
REQ-025 All coordinate comparisons SHALL use 10-bit unsigned arithmetic; random fields are zero-extended.

Reset
REQ-026 On reset=0, asynchronously: state IDLE, busy 0, fruta_wenable 0, map_renable 0, map_rx/map_ry 0, mapa_cheio 0, fruta_wx 13, fruta_wy 13, LFSR seed, counters 0.
REQ-027 Reset mid-search SHALL abort with no fruta_wenable pulse; fruta_wx/fruta_wy return to 13/13.

Structure
REQ-028 Cell encodings (00/01/10/11), state encoding and the 13/13 initial fruit position SHALL live in the shared snake game package, also used by the update stage.
REQ-029 The LFSR SHALL be a separate sub-module lfsr16 (clk, reset, 16-bit out).

Verification
REQ-030 Empty map model, pulse fruta_enable -> fruta_wenable within 4..40 cycles, position in range, map read at that cell returned 00.
REQ-031 Map all 11 except cell (39,29) -> fruta_wx=39, fruta_wy=29 after MAX_TENT rejects plus a scan; mapa_cheio=0.
REQ-032 Map fully occupied -> fruta_wenable pulse, mapa_cheio=1, fruta_wx/fruta_wy unchanged.
REQ-033 Second fruta_enable pulse while busy=1 -> exactly one fruta_wenable pulse.
REQ-034 reset=0 asserted in CHECA -> no fruta_wenable, outputs 13/13, next request completes normally.
REQ-035 Every map_renable followed next cycle by a CHECA/VARRE_CHECA decision; map_rx<40, map_ry<30 at every read strobe.
